// File: rtl/spi_slave_rx_pkg.sv
// Purpose: shared definitions for the SPI mode-0 slave (frame width, underrun byte, FSM states).
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Contents: SPI_DATA_W, SPI_DEFAULT_TX, spi_state_e (encodings shared with spi_master users).
package spi_slave_rx_pkg;

    localparam int SPI_DATA_W = 8;
    localparam logic [SPI_DATA_W-1:0] SPI_DEFAULT_TX = 8'hFF;

    typedef enum logic {
        SPI_S_IDLE   = 1'b0,
        SPI_S_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_slave_rx_if.sv
// Purpose: local-core side of the SPI slave: reply bytes in, received bytes and status strobes out.
// Latency: n/a (wiring only).
// Backpressure: tx_* is valid/ready; rx_valid is a strobe with no back-pressure.
// Modports: slave = SPI block view, master = local core view.
interface spi_slave_rx_if
    import spi_slave_rx_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              tx_underrun;
    logic              frame_err;
    logic              busy;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, rx_data, rx_valid, tx_underrun, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_rx_sync.sv
// Purpose: STAGES-flop synchroniser for one asynchronous input bit, with a chosen reset value.
// Latency: STAGES clk cycles.
// Backpressure: none.
// Ports: clk, reset (sync, active-high), d (async input), q (synchronised output).
module spi_slave_rx_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];
endmodule

// File: rtl/spi_slave_rx.sv
// Purpose: SPI mode-0 slave; receives MSB-first bytes on mosi, returns a reply byte per frame on miso.
// Latency: rx_valid SYNC_STAGES+1 clk after the clk edge that first captures the last sclk high.
// Backpressure: one-entry reply buffer (tx_ready = empty); rx_valid strobe cannot be stalled.
// Ports: clk, reset (sync, active-high); SPI pins sclk, cs_n, mosi, miso, miso_oe;
//        core (slave modport): tx_data/tx_valid/tx_ready, rx_data/rx_valid, tx_underrun, frame_err, busy.
module spi_slave_rx
    import spi_slave_rx_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] DEFAULT_TX  = SPI_DEFAULT_TX
) (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic miso_oe,
    spi_slave_rx_if.slave core
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Synchronised pins
    logic sclk_s, cs_n_s, mosi_s;

    spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .d(sclk), .q(sclk_s)
    );
    spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .reset(reset), .d(cs_n), .q(cs_n_s)
    );
    spi_slave_rx_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .d(mosi), .q(mosi_s)
    );

    // Edge strobes are registered so the FSM sees clean one-cycle pulses;
    // mosi_d is delayed by the same cycle so it lines up with sclk_rise.
    logic sclk_d, cs_n_d, mosi_d;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_d    <= 1'b0;
            cs_n_d    <= 1'b1;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_rise   <= 1'b0;
            cs_fall   <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_n_d    <= cs_n_s;
            mosi_d    <= mosi_s;
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            cs_rise   <= cs_n_s & ~cs_n_d;
            cs_fall   <= ~cs_n_s & cs_n_d;
        end
    end

    // FSM
    spi_state_e state_q, state_d;
    logic [CNT_W-1:0] bit_cnt;
    logic load, shift_rx, shift_tx, end_frame;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SPI_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cs_n rise is checked first so a coincident sclk edge is dropped.
    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        shift_rx  = 1'b0;
        shift_tx  = 1'b0;
        end_frame = 1'b0;
        case (state_q)
            SPI_S_IDLE: begin
                if (cs_fall) begin
                    state_d = SPI_S_ACTIVE;
                    load    = 1'b1;
                end
            end
            SPI_S_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = SPI_S_IDLE;
                    end_frame = 1'b1;
                end else if (sclk_rise) begin
                    shift_rx = 1'b1;
                end else if (sclk_fall) begin
                    // Falling edge on a byte boundary starts the next reply byte.
                    if (bit_cnt == '0) begin
                        load = 1'b1;
                    end else begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: state_d = SPI_S_IDLE;
        endcase
    end

    // Datapath
    logic [DATA_W-1:0] tx_shift;
    logic [DATA_W-2:0] rx_shift;   // bits received so far; the last bit completes the byte
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q, tx_underrun_q, frame_err_q, miso_oe_q;
    logic              accept;

    assign accept = core.tx_valid & ~buf_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            buf_data      <= '0;
            buf_full      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;
            miso_oe_q     <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_err_q   <= 1'b0;

            if (accept) begin
                buf_data <= core.tx_data;
                buf_full <= 1'b1;
            end

            // Accept and load can coincide only with the buffer empty: the load
            // then underruns and the accepted byte waits for the next load.
            if (load) begin
                bit_cnt   <= '0;
                miso_oe_q <= 1'b1;
                if (buf_full) begin
                    tx_shift <= buf_data;
                    buf_full <= 1'b0;
                end else begin
                    tx_shift      <= DEFAULT_TX;
                    tx_underrun_q <= 1'b1;
                end
            end

            if (shift_tx) begin
                tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end

            if (shift_rx) begin
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt    <= '0;
                    rx_data_q  <= {rx_shift, mosi_d};
                    rx_valid_q <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
                rx_shift <= {rx_shift[DATA_W-3:0], mosi_d};
            end

            if (end_frame) begin
                miso_oe_q <= 1'b0;
                tx_shift  <= '0;
                rx_shift  <= '0;
                bit_cnt   <= '0;
                frame_err_q <= (bit_cnt != '0);
            end
        end
    end

    // tx_shift is cleared outside a frame, so miso idles low.
    assign miso             = tx_shift[DATA_W-1];
    assign miso_oe          = miso_oe_q;
    assign core.tx_ready    = ~buf_full;
    assign core.rx_data     = rx_data_q;
    assign core.rx_valid    = rx_valid_q;
    assign core.tx_underrun = tx_underrun_q;
    assign core.frame_err   = frame_err_q;
    assign core.busy        = (state_q == SPI_S_ACTIVE);
endmodule
